mmio_bus_master: RTL and testbench

//  Initiator side of the single-cycle peripheral bus (address/write_data/write_enable/read_enable/read_data)

---
 rtl/mmio_pkg.sv | 75 +++++++
 rtl/mmio_byte_lane.sv | 19 +
 rtl/mmio_bus_master.sv | 155 +++++++++++++++
 tb/tb_mmio_bus_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and lane helpers for the MMIO bus master.
package mmio_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    // Request fields captured on accept
    typedef struct packed {
        logic            write;
        logic            uns;
        logic [1:0]      size;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    // Size 3 is treated as misaligned so it takes the error path
    function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = addr[0];
            SZ_WORD: r = (addr != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] lane_extract(input logic [XLEN-1:0] word,
                                                     input logic [1:0]      addr,
                                                     input logic [1:0]      size,
                                                     input logic            uns);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[{addr, 3'b000} +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      addr,
                                                   input logic [1:0]      size,
                                                   input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{addr, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_byte_lane.sv
// Combinational lane steering: load extraction and sub-word store merge.
module mmio_byte_lane
    import mmio_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [1:0]      size,
    input  logic [XLEN-1:0] wdata,
    input  logic            uns,
    output logic [XLEN-1:0] load_data_c,
    output logic [XLEN-1:0] store_word_c
);

    always_comb begin
        load_data_c  = lane_extract(word, addr, size, uns);
        store_word_c = lane_merge(word, addr, size, wdata);
    end

endmodule

// File: rtl/mmio_bus_master.sv
// Single-outstanding load/store initiator for the peripheral bus; sub-word stores use read-modify-write.
module mmio_bus_master
    import mmio_pkg::*;
#(
    parameter int unsigned READ_WAIT = 0
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] write_data,
    output logic            write_enable,
    output logic            read_enable,
    input  logic [XLEN-1:0] read_data
);

    state_t            state, state_n;
    req_t              lat, lat_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic              req_ready_n, resp_valid_n, resp_error_n;
    logic              write_enable_n, read_enable_n;
    logic [XLEN-1:0]   resp_rdata_n, address_n, write_data_n;
    logic [XLEN-1:0]   load_data_c, store_word_c;

    // Lane logic works on the live bus data so capture happens on the sampling edge
    mmio_byte_lane u_lane (
        .word         (read_data),
        .addr         (lat.addr[1:0]),
        .size         (lat.size),
        .wdata        (lat.wdata),
        .uns          (lat.uns),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    always_comb begin
        state_n        = state;
        lat_n          = lat;
        wait_n         = wait_cnt;
        req_ready_n    = 1'b0;
        resp_valid_n   = 1'b0;
        resp_rdata_n   = resp_rdata;
        resp_error_n   = resp_error;
        address_n      = '0;
        write_data_n   = '0;
        write_enable_n = 1'b0;
        read_enable_n  = 1'b0;

        case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_n  = 1'b0;
                    lat_n.write  = req_write;
                    lat_n.uns    = req_unsigned;
                    lat_n.size   = req_size;
                    lat_n.addr   = req_addr;
                    lat_n.wdata  = req_wdata;
                    resp_rdata_n = '0;
                    resp_error_n = 1'b0;
                    if (is_misaligned(req_addr[1:0], req_size)) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_error_n = 1'b1;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_n        = WR;
                        write_enable_n = 1'b1;
                        address_n      = {req_addr[XLEN-1:2], 2'b00};
                        write_data_n   = req_wdata;
                    end else begin
                        state_n       = RD;
                        read_enable_n = 1'b1;
                        address_n     = {req_addr[XLEN-1:2], 2'b00};
                        wait_n        = WAIT_W'(READ_WAIT);
                    end
                end
            end
            RD: begin
                if (wait_cnt == '0) begin
                    if (lat.write) begin
                        state_n        = WR;
                        write_enable_n = 1'b1;
                        address_n      = {lat.addr[XLEN-1:2], 2'b00};
                        write_data_n   = store_word_c;
                    end else begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_rdata_n = load_data_c;
                    end
                end else begin
                    read_enable_n = 1'b1;
                    address_n     = {lat.addr[XLEN-1:2], 2'b00};
                    wait_n        = wait_cnt - WAIT_W'(1);
                end
            end
            WR: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
            end
            RESP: begin
                resp_valid_n = 1'b1;
                if (resp_ready) begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b0;
                    req_ready_n  = 1'b1;
                    resp_rdata_n = '0;
                    resp_error_n = 1'b0;
                end
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat          <= '0;
            wait_cnt     <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
        end else begin
            state        <= state_n;
            lat          <= lat_n;
            wait_cnt     <= wait_n;
            req_ready    <= req_ready_n;
            resp_valid   <= resp_valid_n;
            resp_rdata   <= resp_rdata_n;
            resp_error   <= resp_error_n;
            address      <= address_n;
            write_data   <= write_data_n;
            write_enable <= write_enable_n;
            read_enable  <= read_enable_n;
        end
    end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: vector table plus wait-state and reset-mid-store sequences.
module tb_mmio_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_write, req_unsigned, resp_ready;
    logic [31:0] req_addr, req_wdata, read_data;
    logic [1:0]  req_size;

    logic        a_req_ready, a_resp_valid, a_resp_error, a_we, a_re;
    logic [31:0] a_resp_rdata, a_address, a_write_data;
    logic        b_req_ready, b_resp_valid, b_resp_error, b_we, b_re;
    logic [31:0] b_resp_rdata, b_address, b_write_data;

    logic        req_ready, resp_valid, resp_error, write_enable, read_enable;
    logic [31:0] resp_rdata, address, write_data;

    always #5 clk = ~clk;

    mmio_bus_master #(.READ_WAIT(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
        .resp_rdata(a_resp_rdata), .resp_error(a_resp_error),
        .address(a_address), .write_data(a_write_data),
        .write_enable(a_we), .read_enable(a_re), .read_data(read_data)
    );

    mmio_bus_master #(.READ_WAIT(3)) dut_w3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error),
        .address(b_address), .write_data(b_write_data),
        .write_enable(b_we), .read_enable(b_re), .read_data(read_data)
    );

    assign req_ready    = sel ? b_req_ready    : a_req_ready;
    assign resp_valid   = sel ? b_resp_valid   : a_resp_valid;
    assign resp_error   = sel ? b_resp_error   : a_resp_error;
    assign resp_rdata   = sel ? b_resp_rdata   : a_resp_rdata;
    assign address      = sel ? b_address      : a_address;
    assign write_data   = sel ? b_write_data   : a_write_data;
    assign write_enable = sel ? b_we           : a_we;
    assign read_enable  = sel ? b_re           : a_re;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          we_cnt;
        int          re_cnt;
        logic [31:0] exp_wd;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] sz, input logic u, input logic [31:0] rd,
                                input logic [31:0] er, input logic ee, input int lat,
                                input int we, input int re, input logic [31:0] ewd);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.size = sz; v.uns = u; v.rd = rd;
        v.exp_rdata = er; v.exp_err = ee; v.lat = lat; v.we_cnt = we; v.re_cnt = re;
        v.exp_wd = ewd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        check({name, "/ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic drive_req(input vec_t v);
        req_valid    = 1'b1;
        req_write    = v.write;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_size     = v.size;
        req_unsigned = v.uns;
        read_data    = v.rd;
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "/sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "/rdata"}, resp_rdata, e.rdata);
            check({name, "/error"}, 32'(resp_error), 32'(e.err));
        end
    endtask

    task automatic run_req(input vec_t v, input string name);
        int   n, we, re;
        exp_t e;
        wait_ready(name);
        drive_req(v);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
        n = 1; we = 0; re = 0;
        while (!resp_valid && n < 40) begin
            if (write_enable) begin
                we++;
                check({name, "/wdata"}, write_data, v.exp_wd);
                check({name, "/waddr"}, address, {v.addr[31:2], 2'b00});
            end
            if (read_enable) begin
                re++;
                if (address !== {v.addr[31:2], 2'b00})
                    check({name, "/raddr"}, address, {v.addr[31:2], 2'b00});
            end
            if (!write_enable && !read_enable && (address !== 32'd0 || write_data !== 32'd0))
                check({name, "/bus_idle"}, address | write_data, 32'd0);
            tick();
            n++;
        end
        check({name, "/latency"}, 32'(n), 32'(v.lat));
        check({name, "/we_cycles"}, 32'(we), 32'(v.we_cnt));
        check({name, "/re_cycles"}, 32'(re), 32'(v.re_cnt));
        resp_ready = 1'b1;
        pop_check(name);
        tick();
        resp_ready = 1'b0;
        check({name, "/done"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    vec_t vt[14];
    vec_t v;

    initial begin
        rst = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0; read_data = '0;

        //        w     addr          wdata         sz    u     read_data     exp_rdata     err   lat we re exp_wdata
        vt[0]  = mk(1'b1, 32'hA000_0000, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 2, 1, 0, 32'hDEAD_BEEF);
        vt[1]  = mk(1'b0, 32'hA000_0003, 32'h0,        2'd0, 1'b0, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 2, 0, 1, 32'h0);
        vt[2]  = mk(1'b0, 32'hA000_0003, 32'h0,        2'd0, 1'b1, 32'h80FF_1234, 32'h0000_0080, 1'b0, 2, 0, 1, 32'h0);
        vt[3]  = mk(1'b1, 32'hA000_0002, 32'h0000_ABCD, 2'd1, 1'b0, 32'h1111_2222, 32'h0,        1'b0, 3, 1, 1, 32'hABCD_2222);
        vt[4]  = mk(1'b0, 32'hA000_0001, 32'h0,        2'd2, 1'b0, 32'h1234_5678, 32'h0,        1'b1, 1, 0, 0, 32'h0);
        vt[5]  = mk(1'b0, 32'hA000_0000, 32'h0,        2'd3, 1'b0, 32'h1234_5678, 32'h0,        1'b1, 1, 0, 0, 32'h0);
        vt[6]  = mk(1'b0, 32'hA000_0000, 32'h0,        2'd1, 1'b0, 32'h1234_8001, 32'hFFFF_8001, 1'b0, 2, 0, 1, 32'h0);
        vt[7]  = mk(1'b0, 32'hA000_0002, 32'h0,        2'd1, 1'b1, 32'h8001_7FFF, 32'h0000_8001, 1'b0, 2, 0, 1, 32'h0);
        vt[8]  = mk(1'b0, 32'hA000_0000, 32'h0,        2'd1, 1'b0, 32'h8001_7FFF, 32'h0000_7FFF, 1'b0, 2, 0, 1, 32'h0);
        vt[9]  = mk(1'b0, 32'hA000_0004, 32'h0,        2'd2, 1'b1, 32'h8765_4321, 32'h8765_4321, 1'b0, 2, 0, 1, 32'h0);
        vt[10] = mk(1'b1, 32'hA000_0001, 32'hFFFF_FF5A, 2'd0, 1'b0, 32'h1122_3344, 32'h0,        1'b0, 3, 1, 1, 32'h1122_5A44);
        vt[11] = mk(1'b1, 32'hA000_0003, 32'h0000_1234, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);
        vt[12] = mk(1'b0, 32'hA000_0002, 32'h0,        2'd0, 1'b0, 32'h007F_0000, 32'h0000_007F, 1'b0, 2, 0, 1, 32'h0);
        vt[13] = mk(1'b1, 32'hA000_0002, 32'hCAFE_CAFE, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0);

        #2;
        check("reset/ready_valid", {30'd0, req_ready, resp_valid}, 32'd2);
        check("reset/strobes", {30'd0, write_enable, read_enable}, 32'd0);
        check("reset/bus", address | write_data | resp_rdata, 32'd0);
        check("reset/error", 32'(resp_error), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_req(vt[i], $sformatf("vec%0d", i));
        end

        // Wait states: junk on the bus until the 4th read cycle, then back-pressure
        sel = 1'b1;
        tick();
        v = mk(1'b0, 32'hA000_0008, 32'h0, 2'd2, 1'b0, 32'h5555_5555, 32'hCAFE_F00D, 1'b0, 5, 0, 4, 32'h0);
        wait_ready("rw3");
        drive_req(v);
        sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("rw3/re_cyc%0d", k), {30'd0, read_enable, resp_valid}, 32'd2);
            read_data = (k == 4) ? 32'hCAFE_F00D : 32'h5555_5555 + 32'(k);
            tick();
        end
        read_data = 32'h0BAD_0BAD;
        check("rw3/re_off", 32'(read_enable), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rw3/hold%0d", k), {resp_rdata[31:2], resp_valid, req_ready},
                  {30'(32'hCAFE_F00D >> 2), 1'b1, 1'b0});
            tick();
        end
        resp_ready = 1'b1;
        pop_check("rw3");
        tick();
        resp_ready = 1'b0;
        check("rw3/done", {30'd0, resp_valid, req_ready}, 32'd1);

        // Reset while a byte store is in its write cycle
        sel = 1'b0;
        tick();
        v = mk(1'b1, 32'hA000_0000, 32'h0000_0055, 2'd0, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 3, 1, 1, 32'h1122_3355);
        wait_ready("rst_wr");
        drive_req(v);
        tick();
        req_valid = 1'b0;
        check("rst_wr/rd", 32'(read_enable), 32'd1);
        tick();
        check("rst_wr/wr", {write_enable, write_data[30:0]}, {1'b1, 31'h1122_3355});
        rst = 1'b1;
        #1;
        check("rst_wr/strobes", {30'd0, write_enable, read_enable}, 32'd0);
        check("rst_wr/bus", address | write_data | resp_rdata, 32'd0);
        check("rst_wr/ready_valid", {30'd0, req_ready, resp_valid}, 32'd2);
        tick();
        tick();
        rst = 1'b0;
        v = mk(1'b0, 32'hA000_000C, 32'h0, 2'd2, 1'b0, 32'h0102_0304, 32'h0102_0304, 1'b0, 2, 0, 1, 32'h0);
        run_req(v, "post_rst");

        check("sb/empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
